// File: rtl/histogram_sequencer.sv
// Frame controller for computeHistogram: scan, readout and clear of one frame per request.
// Optional watchdog enabled by defining HIST_SEQ_TIMEOUT_EN.
module histogram_sequencer #(
    parameter int unsigned IMG_W          = 240,
    parameter int unsigned IMG_H          = 180,
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frameStart,
    input  logic              abort,
    output logic              busy,
    output logic              frameDone,
    output logic              pixRdEn,
    output logic [ADDR_W-1:0] pixRdX,
    output logic [ADDR_W-1:0] pixRdY,
    input  logic              pixRdData,
    output logic [ADDR_W-1:0] xAddress,
    output logic [ADDR_W-1:0] yAddress,
    output logic              pixelData,
    output logic              startHistogram,
    output logic              readHistogram,
    output logic              clearHistogram,
    input  logic [ADDR_W-1:0] xHistogramOut,
    input  logic [ADDR_W-1:0] yHistogramOut,
    input  logic              xValid,
    input  logic              yValid,
    input  logic              histogramClear,
    output logic [ADDR_W-1:0] xResult,
    output logic [ADDR_W-1:0] xResultIndex,
    output logic              xResultValid,
    output logic [ADDR_W-1:0] yResult,
    output logic [ADDR_W-1:0] yResultIndex,
    output logic              yResultValid,
    output logic              timeoutErr
);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        FLUSH,
        READ,
        CLEAR,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] X_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST = ADDR_W'(IMG_H - 1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] x_cnt_reg, x_cnt_next;
    logic [ADDR_W-1:0] y_cnt_reg, y_cnt_next;
    logic [ADDR_W-1:0] stage_x_reg, stage_y_reg;
    logic              stage_en_reg;
    logic              wd_expire;

    logic              frame_accept;
    logic              read_active;
    logic [1:0]        bin_valid;
    logic [ADDR_W-1:0] bin_in        [2];
    logic [ADDR_W-1:0] res_data_reg  [2];
    logic [ADDR_W-1:0] res_index_reg [2];
    logic [ADDR_W-1:0] bin_cnt_reg   [2];
    logic [1:0]        res_valid_reg;
    logic [1:0]        bin_full_reg;

    assign frame_accept = (state_reg == IDLE) && frameStart && !abort;
    assign read_active  = (state_reg == READ) && !abort;

    always_comb begin
        state_next = state_reg;
        x_cnt_next = x_cnt_reg;
        y_cnt_next = y_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (frame_accept) state_next = SCAN;
            end
            SCAN: begin
                if (abort) begin
                    state_next = CLEAR;
                    x_cnt_next = '0;
                    y_cnt_next = '0;
                end else if (y_cnt_reg == Y_LAST) begin
                    y_cnt_next = '0;
                    if (x_cnt_reg == X_LAST) begin
                        x_cnt_next = '0;
                        state_next = FLUSH;
                    end else begin
                        x_cnt_next = x_cnt_reg + 1'b1;
                    end
                end else begin
                    y_cnt_next = y_cnt_reg + 1'b1;
                end
            end
            FLUSH:   state_next = abort ? CLEAR : READ;
            READ: begin
                if (abort || (&bin_full_reg)) state_next = CLEAR;
            end
            CLEAR: begin
                if (histogramClear) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A watchdog expiry overrides waiting in READ or CLEAR.
        if (wd_expire) state_next = (state_reg == READ) ? CLEAR : DONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            x_cnt_reg    <= '0;
            y_cnt_reg    <= '0;
            stage_x_reg  <= '0;
            stage_y_reg  <= '0;
            stage_en_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            x_cnt_reg    <= x_cnt_next;
            y_cnt_reg    <= y_cnt_next;
            stage_x_reg  <= x_cnt_reg;
            stage_y_reg  <= y_cnt_reg;
            stage_en_reg <= pixRdEn;
        end
    end

    assign bin_valid = {yValid, xValid};
    assign bin_in[0] = xHistogramOut;
    assign bin_in[1] = yHistogramOut;

    // Channel 0 forwards x bins, channel 1 forwards y bins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bin
            localparam logic [ADDR_W-1:0] BIN_LAST = ADDR_W'(((gi == 0) ? IMG_W : IMG_H) - 1);
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    res_data_reg[gi]  <= '0;
                    res_index_reg[gi] <= '0;
                    res_valid_reg[gi] <= 1'b0;
                    bin_cnt_reg[gi]   <= '0;
                    bin_full_reg[gi]  <= 1'b0;
                end else begin
                    res_valid_reg[gi] <= 1'b0;
                    if (frame_accept) begin
                        bin_cnt_reg[gi]  <= '0;
                        bin_full_reg[gi] <= 1'b0;
                    end else if (read_active && bin_valid[gi] && !bin_full_reg[gi]) begin
                        res_data_reg[gi]  <= bin_in[gi];
                        res_index_reg[gi] <= bin_cnt_reg[gi];
                        res_valid_reg[gi] <= 1'b1;
                        if (bin_cnt_reg[gi] == BIN_LAST) bin_full_reg[gi] <= 1'b1;
                        else bin_cnt_reg[gi] <= bin_cnt_reg[gi] + 1'b1;
                    end
                end
            end
        end
    endgenerate

`ifdef HIST_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt_reg;
    logic            wd_idle;
    logic            timeout_err_reg;

    assign wd_idle   = ((state_reg == READ) && !abort && !xValid && !yValid) ||
                       ((state_reg == CLEAR) && !histogramClear);
    assign wd_expire = wd_idle && (wd_cnt_reg == WD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt_reg      <= '0;
            timeout_err_reg <= 1'b0;
        end else begin
            if (state_next != state_reg || !wd_idle) wd_cnt_reg <= '0;
            else wd_cnt_reg <= wd_cnt_reg + 1'b1;
            if (frame_accept) timeout_err_reg <= 1'b0;
            else if (wd_expire) timeout_err_reg <= 1'b1;
        end
    end

    assign timeoutErr = timeout_err_reg;
`else
    assign wd_expire  = 1'b0;
    assign timeoutErr = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    // abort gates the strobes combinationally so nothing is issued in the abort cycle.
    assign busy           = (state_reg != IDLE);
    assign frameDone      = (state_reg == DONE);
    assign pixRdEn        = (state_reg == SCAN) && !abort;
    assign pixRdX         = x_cnt_reg;
    assign pixRdY         = y_cnt_reg;
    assign xAddress       = stage_x_reg;
    assign yAddress       = stage_y_reg;
    assign startHistogram = stage_en_reg && !abort;
    assign pixelData      = stage_en_reg && !abort && pixRdData;
    assign readHistogram  = read_active;
    assign clearHistogram = (state_reg == CLEAR);
    assign xResult        = res_data_reg[0];
    assign xResultIndex   = res_index_reg[0];
    assign xResultValid   = res_valid_reg[0];
    assign yResult        = res_data_reg[1];
    assign yResultIndex   = res_index_reg[1];
    assign yResultValid   = res_valid_reg[1];

endmodule

// File: tb/tb_histogram_sequencer.sv
// Directed-plus-random bench for histogram_sequencer with a frame buffer and bin-source model.
// Watchdog section is built when HIST_SEQ_TIMEOUT_EN is defined.
module tb_histogram_sequencer;

    localparam int W  = 240;
    localparam int H  = 180;
    localparam int AW = 8;
    localparam int TO = 16;
    localparam int N  = W * H;

    logic clk, reset, frameStart, abort, pixRdData, histogramClear;
    logic xValid, yValid;
    logic [AW-1:0] xHistogramOut, yHistogramOut;
    logic busy, frameDone, pixRdEn, pixelData, startHistogram, readHistogram, clearHistogram;
    logic xResultValid, yResultValid, timeoutErr;
    logic [AW-1:0] pixRdX, pixRdY, xAddress, yAddress;
    logic [AW-1:0] xResult, xResultIndex, yResult, yResultIndex;

    histogram_sequencer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .frameStart(frameStart), .abort(abort),
        .busy(busy), .frameDone(frameDone),
        .pixRdEn(pixRdEn), .pixRdX(pixRdX), .pixRdY(pixRdY), .pixRdData(pixRdData),
        .xAddress(xAddress), .yAddress(yAddress), .pixelData(pixelData),
        .startHistogram(startHistogram), .readHistogram(readHistogram),
        .clearHistogram(clearHistogram),
        .xHistogramOut(xHistogramOut), .yHistogramOut(yHistogramOut),
        .xValid(xValid), .yValid(yValid), .histogramClear(histogramClear),
        .xResult(xResult), .xResultIndex(xResultIndex), .xResultValid(xResultValid),
        .yResult(yResult), .yResultIndex(yResultIndex), .yResultValid(yResultValid),
        .timeoutErr(timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit fb [W][H];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return 128'({busy, frameDone, pixRdEn, pixRdX, pixRdY, xAddress, yAddress, pixelData,
                     startHistogram, readHistogram, clearHistogram, xResult, xResultIndex,
                     xResultValid, yResult, yResultIndex, yResultValid, timeoutErr});
    endfunction

    // Frame buffer: one-cycle read latency.
    initial begin
        bit nb;
        pixRdData = 1'b0;
        forever begin
            @(negedge clk);
            nb = (pixRdEn && pixRdX < W && pixRdY < H) ? fb[pixRdX][pixRdY] : 1'b0;
            @(posedge clk);
            #1 pixRdData = nb;
        end
    end

    // Entered at the negedge where clearHistogram is first seen high.
    task automatic do_clear(input int n, input string tag);
        int hi = 0;
        for (int c = 0; c < 40; c++) begin
            if (!clearHistogram) break;
            hi++;
            histogramClear = (hi == n);
            @(negedge clk);
        end
        histogramClear = 1'b0;
        check({tag, "_clear_len"}, hi, n);
        check({tag, "_done_pulse"}, frameDone, 1'b1);
        check({tag, "_busy_in_done"}, busy, 1'b1);
        @(negedge clk);
        check({tag, "_done_once"}, frameDone, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        $display("[tb] %s clear handshake: %0d cycles", tag, hi);
    endtask

    initial begin
        int x_sent, y_sent, x_model, y_model, guard;
        logic exv, eyv;
        logic [AW-1:0] exd, exi, eyd, eyi;
        bit done;

        for (int x = 0; x < W; x++)
            for (int y = 0; y < H; y++) fb[x][y] = 1'($urandom);
        reset = 1'b0; frameStart = 1'b0; abort = 1'b0; histogramClear = 1'b0;
        xValid = 1'b0; yValid = 1'b0; xHistogramOut = '0; yHistogramOut = '0;

        repeat (3) @(negedge clk);
        check("reset_outputs", all_outs(), 128'd0);
        reset = 1'b1;
        @(negedge clk);
        check("idle_after_reset", all_outs(), 128'd0);
        $display("[tb] reset: outputs zero");

        frameStart = 1'b1; abort = 1'b1;
        @(negedge clk);
        frameStart = 1'b0; abort = 1'b0;
        check("abort_priority_busy", busy, 1'b0);
        check("abort_priority_rden", pixRdEn, 1'b0);
        $display("[tb] frameStart with abort in IDLE: stays idle");

        // Frame 1: full scan with a stray frameStart mid-scan.
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        check("start_rden", pixRdEn, 1'b1);
        check("start_rd_xy", {pixRdX, pixRdY}, 16'h0000);
        check("start_hist_late", startHistogram, 1'b0);
        check("start_busy", busy, 1'b1);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            frameStart = 1'b0;
            check("scan_start", startHistogram, 1'b1);
            check("scan_xaddr", xAddress, k / H);
            check("scan_yaddr", yAddress, k % H);
            check("scan_pixel", pixelData, fb[k / H][k % H]);
            check("scan_no_read", readHistogram, 1'b0);
            check("scan_rden", pixRdEn, k < N - 1);
            if (k < N - 1) check("scan_rd_xy", {pixRdX, pixRdY}, {8'((k + 1) / H), 8'((k + 1) % H)});
            if (k == 100) frameStart = 1'b1;
        end
        @(negedge clk);
        check("scan_end_start", startHistogram, 1'b0);
        check("read_rises", readHistogram, 1'b1);
        $display("[tb] frame1 scan: %0d pixels", N);

        // Readout with random gaps; an extra x beat beyond W must be dropped.
        x_sent = 0; y_sent = 0; x_model = 0; y_model = 0;
        exv = 1'b0; eyv = 1'b0; exd = '0; exi = '0; eyd = '0; eyi = '0; done = 1'b0;
        for (guard = 0; guard < 3000; guard++) begin
            check("read_active", readHistogram, 1'b1);
            check("x_res_valid", xResultValid, exv);
            if (exv) check("x_res", {xResult, xResultIndex}, {exd, exi});
            check("y_res_valid", yResultValid, eyv);
            if (eyv) check("y_res", {yResult, yResultIndex}, {eyd, eyi});
            if (x_sent == W + 1 && y_sent == H) begin
                done = 1'b1;
                xValid = 1'b0; yValid = 1'b0;
                break;
            end
            xValid = (x_sent < W + 1) && ($urandom_range(0, 1) == 1);
            xHistogramOut = 8'($urandom);
            exv = 1'b0;
            if (xValid) begin
                if (x_model < W) begin
                    exv = 1'b1; exd = xHistogramOut; exi = 8'(x_model); x_model++;
                end
                x_sent++;
            end
            yValid = (y_sent < H) && (y_sent < H - 1 || x_sent == W + 1) && ($urandom_range(0, 1) == 1);
            yHistogramOut = 8'($urandom);
            eyv = 1'b0;
            if (yValid) begin
                eyv = 1'b1; eyd = yHistogramOut; eyi = 8'(y_model); y_model++;
                y_sent++;
            end
            @(negedge clk);
        end
        check("readout_bound", done, 1'b1);
        $display("[tb] frame1 readout: %0d x beats, %0d y beats", x_sent, y_sent);
        for (int c = 0; c < 8 && !clearHistogram; c++) @(negedge clk);
        check("clear_entry", clearHistogram, 1'b1);
        check("clear_no_read", readHistogram, 1'b0);
        do_clear(5, "frame1");

        // Frame 2: restart right after DONE, abort at pixel (10,20).
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        check("restart_rden", pixRdEn, 1'b1);
        for (int c = 0; c < 3000; c++) begin
            if (pixRdX == 10 && pixRdY == 20) break;
            @(negedge clk);
        end
        check("abort_point", {pixRdX, pixRdY}, {8'd10, 8'd20});
        abort = 1'b1;
        #1;
        check("abort_rden_drop", pixRdEn, 1'b0);
        check("abort_hist_drop", startHistogram, 1'b0);
        @(negedge clk);
        abort = 1'b0;
        check("abort_to_clear", clearHistogram, 1'b1);
        check("abort_hist_low", startHistogram, 1'b0);
        check("abort_no_read", readHistogram, 1'b0);
        check("abort_rden_low", pixRdEn, 1'b0);
        $display("[tb] frame2 aborted at (10,20)");
        do_clear(3, "frame2");

        // Frame 3: reach READ, then watchdog or reset mid-operation.
        frameStart = 1'b1;
        @(negedge clk);
        frameStart = 1'b0;
        for (int c = 0; c < 50000 && !readHistogram; c++) @(negedge clk);
        check("frame3_read", readHistogram, 1'b1);
`ifdef HIST_SEQ_TIMEOUT_EN
        begin
            int rd = 0;
            for (int c = 0; c < 40; c++) begin
                if (!readHistogram) break;
                rd++;
                check("wd_not_yet", timeoutErr, 1'b0);
                @(negedge clk);
            end
            check("wd_read_len", rd, TO);
            check("wd_flag", timeoutErr, 1'b1);
            check("wd_to_clear", clearHistogram, 1'b1);
            $display("[tb] frame3 watchdog after %0d idle READ cycles", rd);
        end
`else
        repeat (4) begin
            xValid = 1'b1; yValid = 1'b1; xHistogramOut = 8'($urandom); yHistogramOut = 8'($urandom);
            @(negedge clk);
        end
        xValid = 1'b0; yValid = 1'b0;
        check("mid_read_valid", xResultValid, 1'b1);
`endif
        #2 reset = 1'b0;
        #1;
        check("async_reset_outputs", all_outs(), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", busy, 1'b0);
        check("post_reset_outputs", all_outs(), 128'd0);
        $display("[tb] frame3 reset mid-operation: outputs zero");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
